// File: rtl/ec_pkg.sv
// Shared constants, FSM encoding and offset helper for the AV1 range-update stage.
package ec_pkg;

  localparam int EC_MIN_PROB_DEFAULT = 4;

  // Normalised initial range: the top RANGE_WIDTH bits of this word give 1<<(RANGE_WIDTH-1).
  localparam logic [31:0] RANGE_INIT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } ec_state_e;

  function automatic logic [31:0] ec_offset(input logic [31:0] n, input logic [31:0] k,
                                            input logic [31:0] step);
    if (k <= n) begin
      ec_offset = step * (n - k + 32'd1);
    end else begin
      ec_offset = 32'd0;
    end
  endfunction

endpackage

// File: rtl/ec_min_prob_offset.sv
// Combinational min-probability offset off(N,k); k is one bit wider so k=s+1 never wraps.
module ec_min_prob_offset
  import ec_pkg::*;
#(
  parameter int SYM_WIDTH   = 4,
  parameter int OFF_WIDTH   = 16,
  parameter int EC_MIN_PROB = EC_MIN_PROB_DEFAULT
) (
  input  logic [SYM_WIDTH-1:0] n,
  input  logic [SYM_WIDTH:0]   k,
  output logic [OFF_WIDTH-1:0] off
);

  assign off = OFF_WIDTH'(ec_offset(32'(n), 32'(k), 32'(EC_MIN_PROB)));

endmodule

// File: rtl/ec_range_update.sv
// Range-update stage of the AV1 multi-symbol arithmetic encoder: computes u/v, renormalises
// the range register and hands low-increment and shift count to the low/carry stage.
module ec_range_update
  import ec_pkg::*;
#(
  parameter int SYM_WIDTH   = 4,
  parameter int PROB_WIDTH  = 16,
  parameter int RANGE_WIDTH = 16,
  parameter int EC_MIN_PROB = EC_MIN_PROB_DEFAULT,
  parameter int SHIFT_WIDTH = $clog2(RANGE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_init,
  input  logic [SYM_WIDTH-1:0]   in_n,
  input  logic [SYM_WIDTH-1:0]   in_s,
  input  logic [PROB_WIDTH-1:0]  in_fl,
  input  logic [PROB_WIDTH-1:0]  in_fh,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RANGE_WIDTH-1:0] out_low_add,
  output logic [RANGE_WIDTH-1:0] out_range,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_err
);

  localparam int PW = RANGE_WIDTH + PROB_WIDTH;
  localparam logic [RANGE_WIDTH-1:0] R_INIT = RANGE_INIT[31 -: RANGE_WIDTH];

  ec_state_e              state_r, state_next_s;
  logic                   out_valid_r;
  logic [RANGE_WIDTH-1:0] range_r;
  logic [RANGE_WIDTH-1:0] low_add_r, out_range_r;
  logic [SHIFT_WIDTH-1:0] shift_r;
  logic                   err_r;

  logic [RANGE_WIDTH-1:0] pfl_r, pfh_r, off_lo_r, off_hi_r;
  logic                   sym_zero_r, sym_err_r;

  logic                   in_ready_s, accept_s, sym_err_s;
  logic [RANGE_WIDTH-1:0] r_eff_s, pfl_s, pfh_s, off_lo_s, off_hi_s;
  logic [SYM_WIDTH:0]     k_lo_s, k_hi_s;
  logic [RANGE_WIDTH-1:0] u_s, v_s, rnew_s, low_s, norm_s;
  logic [SHIFT_WIDTH-1:0] msb_s, d_s;
  logic                   unused_s;

  assign in_ready_s = (state_r == IDLE) | ((state_r == OUT) & out_ready);
  assign accept_s   = in_valid & in_ready_s;
  assign sym_err_s  = (in_s > in_n);
  assign r_eff_s    = in_init ? R_INIT : range_r;

  // Products use the truncated operands (R>>8, f>>6) so the low input bits never contribute.
  assign pfl_s = RANGE_WIDTH'((PW'(r_eff_s[RANGE_WIDTH-1:8]) * PW'(in_fl[PROB_WIDTH-1:6])) >> 1);
  assign pfh_s = RANGE_WIDTH'((PW'(r_eff_s[RANGE_WIDTH-1:8]) * PW'(in_fh[PROB_WIDTH-1:6])) >> 1);
  assign unused_s = ^{in_fl[5:0], in_fh[5:0]};

  assign k_lo_s = {1'b0, in_s};
  assign k_hi_s = {1'b0, in_s} + {{SYM_WIDTH{1'b0}}, 1'b1};

  ec_min_prob_offset #(
    .SYM_WIDTH  (SYM_WIDTH),
    .OFF_WIDTH  (RANGE_WIDTH),
    .EC_MIN_PROB(EC_MIN_PROB)
  ) u_off_lo (
    .n  (in_n),
    .k  (k_lo_s),
    .off(off_lo_s)
  );

  ec_min_prob_offset #(
    .SYM_WIDTH  (SYM_WIDTH),
    .OFF_WIDTH  (RANGE_WIDTH),
    .EC_MIN_PROB(EC_MIN_PROB)
  ) u_off_hi (
    .n  (in_n),
    .k  (k_hi_s),
    .off(off_hi_s)
  );

  // Next-state logic for the IDLE/CALC/OUT handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: state_next_s = OUT;
      OUT: begin
        if (out_ready & in_valid) begin
          state_next_s = CALC;
        end else if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OUT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Interval arithmetic and renormalisation from the registered products and offsets.
  always_comb begin
    u_s = pfl_r + off_lo_r;
    v_s = pfh_r + off_hi_r;
    if (sym_zero_r) begin
      rnew_s = range_r - v_s;
      low_s  = {RANGE_WIDTH{1'b0}};
    end else begin
      rnew_s = u_s - v_s;
      low_s  = range_r - u_s;
    end
    msb_s = {SHIFT_WIDTH{1'b0}};
    for (int i = 0; i < RANGE_WIDTH; i++) begin
      msb_s = rnew_s[i] ? SHIFT_WIDTH'(i) : msb_s;
    end
    d_s    = SHIFT_WIDTH'(RANGE_WIDTH - 1) - msb_s;
    norm_s = rnew_s << d_s;
  end

  // FSM state and the registered result-valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == OUT);
    end
  end

  // Capture products, offsets and symbol class when a tuple is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pfl_r      <= {RANGE_WIDTH{1'b0}};
      pfh_r      <= {RANGE_WIDTH{1'b0}};
      off_lo_r   <= {RANGE_WIDTH{1'b0}};
      off_hi_r   <= {RANGE_WIDTH{1'b0}};
      sym_zero_r <= 1'b0;
      sym_err_r  <= 1'b0;
    end else if (accept_s) begin
      pfl_r      <= pfl_s;
      pfh_r      <= pfh_s;
      off_lo_r   <= off_lo_s;
      off_hi_r   <= off_hi_s;
      sym_zero_r <= (in_s == {SYM_WIDTH{1'b0}});
      sym_err_r  <= sym_err_s;
    end
  end

  // Range register and result outputs; an erroneous symbol leaves the range untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      range_r     <= R_INIT;
      low_add_r   <= {RANGE_WIDTH{1'b0}};
      out_range_r <= {RANGE_WIDTH{1'b0}};
      shift_r     <= {SHIFT_WIDTH{1'b0}};
      err_r       <= 1'b0;
    end else if (state_r == CALC) begin
      if (sym_err_r) begin
        err_r       <= 1'b1;
        low_add_r   <= {RANGE_WIDTH{1'b0}};
        shift_r     <= {SHIFT_WIDTH{1'b0}};
        out_range_r <= range_r;
      end else begin
        err_r       <= 1'b0;
        low_add_r   <= low_s;
        shift_r     <= d_s;
        out_range_r <= norm_s;
        range_r     <= norm_s;
      end
    end else if (accept_s) begin
      range_r <= r_eff_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_low_add = low_add_r;
  assign out_range   = out_range_r;
  assign out_shift   = shift_r;
  assign out_err     = err_r;

endmodule

// File: tb/tb_ec_range_update.sv
// Directed table-driven bench for ec_range_update plus throughput, stall and reset sequences.
module tb_ec_range_update;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_init;
  logic [3:0]  in_n, in_s;
  logic [15:0] in_fl, in_fh;
  logic        out_valid, out_ready;
  logic [15:0] out_low_add, out_range;
  logic [3:0]  out_shift;
  logic        out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        init;
    logic [3:0]  n;
    logic [3:0]  s;
    logic [15:0] fl;
    logic [15:0] fh;
    logic [15:0] low;
    logic [15:0] rng;
    logic [3:0]  sh;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  ec_range_update dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_init    (in_init),
    .in_n       (in_n),
    .in_s       (in_s),
    .in_fl      (in_fl),
    .in_fh      (in_fh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_low_add(out_low_add),
    .out_range  (out_range),
    .out_shift  (out_shift),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic i, input logic [3:0] n, input logic [3:0] s,
                              input logic [15:0] fl, input logic [15:0] fh,
                              input logic [15:0] low, input logic [15:0] rng,
                              input logic [3:0] sh, input logic e);
    vec_t r;
    r.init = i; r.n = n; r.s = s; r.fl = fl; r.fh = fh;
    r.low = low; r.rng = rng; r.sh = sh; r.err = e;
    return r;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    @(negedge clk);
    in_init = v.init; in_n = v.n; in_s = v.s; in_fl = v.fl; in_fh = v.fh;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready", idx, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("valid_calc", idx, 32'(out_valid), 32'd0);
    @(negedge clk);
    check("valid_out", idx, 32'(out_valid), 32'd1);
    check("low_add", idx, 32'(out_low_add), 32'(v.low));
    check("range", idx, 32'(out_range), 32'(v.rng));
    check("shift", idx, 32'(out_shift), 32'(v.sh));
    check("err", idx, 32'(out_err), 32'(v.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    int prev;
    int k;

    tbl.push_back(mk(1'b1, 4'd1, 4'd0, 16'd0,     16'd16384, 16'h0000, 16'hFFF0, 4'd2,  1'b0));
    tbl.push_back(mk(1'b0, 4'd1, 4'd1, 16'd16384, 16'd0,     16'h806C, 16'hFF08, 4'd1,  1'b0));
    tbl.push_back(mk(1'b1, 4'd1, 4'd1, 16'd16384, 16'd0,     16'h3FFC, 16'h8008, 4'd1,  1'b0));
    tbl.push_back(mk(1'b0, 4'd1, 4'd2, 16'h1234,  16'h0567,  16'h0000, 16'h8008, 4'd0,  1'b1));
    tbl.push_back(mk(1'b0, 4'd1, 4'd0, 16'd0,     16'd16384, 16'h0000, 16'h8008, 4'd1,  1'b0));
    tbl.push_back(mk(1'b1, 4'd1, 4'd3, 16'h4000,  16'h2000,  16'h0000, 16'h8000, 4'd0,  1'b1));
    tbl.push_back(mk(1'b0, 4'd1, 4'd1, 16'd16384, 16'd0,     16'h3FFC, 16'h8008, 4'd1,  1'b0));
    tbl.push_back(mk(1'b1, 4'd3, 4'd2, 16'd20000, 16'd8000,  16'h31F8, 16'hBB10, 4'd2,  1'b0));
    tbl.push_back(mk(1'b1, 4'd7, 4'd0, 16'd0,     16'd30000, 16'h0000, 16'hAE40, 4'd4,  1'b0));
    tbl.push_back(mk(1'b1, 4'd3, 4'd5, 16'd100,   16'd50,    16'h0000, 16'h8000, 4'd0,  1'b1));
    tbl.push_back(mk(1'b1, 4'd15, 4'd0, 16'd0,    16'd0,     16'h0000, 16'hFF88, 4'd1,  1'b0));
    // With fl=fh=0 the new range is always 4, so low_add exposes off(15,s) = 4*(16-s).
    for (int s = 1; s <= 15; s++) begin
      tbl.push_back(mk(1'b1, 4'd15, 4'(s), 16'd0, 16'd0,
                       16'h8000 - 16'(4 * (16 - s)), 16'h8000, 4'd13, 1'b0));
    end

    reset = 1'b1; in_valid = 1'b0; in_init = 1'b0; in_n = 4'd0; in_s = 4'd0;
    in_fl = 16'd0; in_fh = 16'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 0, 32'(out_valid), 32'd0);
    check("rst_low", 0, 32'(out_low_add), 32'd0);
    check("rst_range", 0, 32'(out_range), 32'd0);
    check("rst_shift", 0, 32'(out_shift), 32'd0);
    check("rst_err", 0, 32'(out_err), 32'd0);
    check("rst_ready", 0, 32'(in_ready), 32'd1);
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Back-to-back tuples: results must alternate, one every two cycles.
    @(negedge clk);
    in_init = 1'b1; in_n = 4'd15; in_s = 4'd5; in_fl = 16'd0; in_fh = 16'd0;
    in_valid = 1'b1;
    highs = 0; prev = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) highs++;
      check("b2b_alt", c, 32'(prev != 0 && out_valid), 32'd0);
      prev = int'(out_valid);
    end
    check("b2b_count", 0, 32'(highs), 32'd6);

    k = 0;
    while (!out_valid && k < 4) begin
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_valid", c, 32'(out_valid), 32'd1);
      check("stall_ready", c, 32'(in_ready), 32'd0);
      check("stall_low", c, 32'(out_low_add), 32'h7FD4);
      check("stall_range", c, 32'(out_range), 32'h8000);
      check("stall_shift", c, 32'(out_shift), 32'd13);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release", 0, 32'(out_valid), 32'd0);

    // Reset while a symbol is in CALC drops it and restores the initial range.
    run_vec(mk(1'b1, 4'd1, 4'd0, 16'd0, 16'd16384, 16'h0000, 16'hFFF0, 4'd2, 1'b0), 100);
    @(negedge clk);
    in_init = 1'b0; in_n = 4'd1; in_s = 4'd1; in_fl = 16'd16384; in_fh = 16'd0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("calc_rst_valid", 0, 32'(out_valid), 32'd0);
    check("calc_rst_range", 0, 32'(out_range), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 0, 32'(out_valid), 32'd0);
    run_vec(mk(1'b0, 4'd1, 4'd1, 16'd16384, 16'd0, 16'h3FFC, 16'h8008, 4'd1, 1'b0), 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
